gpio_pad_bridge: RTL



---
 rtl/gpio_pad_bridge.sv | 115 +++++++++++
 1 files changed

// File: rtl/gpio_pad_bridge.sv
// gpio_pad_bridge: 32-pin GPIO pad stage for the E300 platform port.
// Tristate pad drive out; gated, synchronised, optionally debounced in.
//
// Ports:
//   clock, erst_n      core clock, async active-low reset
//   gpio               board pads (inout)
//   e300_gpio_o_oval   platform output value
//   e300_gpio_o_oe     platform output enable
//   e300_gpio_o_ie     platform input enable
//   e300_gpio_i_ival   conditioned input level to platform
//   gpio_rise          1-cycle pulse on ival 0->1
//   gpio_fall          1-cycle pulse on ival 1->0
//
// Build option: define GPIO_DEBOUNCE_EN to add the per-bit
// debounce filter between the synchroniser and ival.

module gpio_pad_bridge #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             erst_n,
  inout  wire  [WIDTH-1:0] gpio,
  input  logic [WIDTH-1:0] e300_gpio_o_oval,
  input  logic [WIDTH-1:0] e300_gpio_o_oe,
  input  logic [WIDTH-1:0] e300_gpio_o_ie,
  output logic [WIDTH-1:0] e300_gpio_i_ival,
  output logic [WIDTH-1:0] gpio_rise,
  output logic [WIDTH-1:0] gpio_fall
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("gpio_pad_bridge: SYNC_STAGES must be 2..4");
  end

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
    $error("gpio_pad_bridge: DEBOUNCE_CYCLES must be 2..65535");
  end

  // Pad drivers: combinational, independent of reset.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign gpio[i] = e300_gpio_o_oe[i] ? e300_gpio_o_oval[i] : 1'bz;
  end

  // Driven pads are read back too, so outputs loop to their own input.
  logic [WIDTH-1:0] raw;
  assign raw = gpio & e300_gpio_o_ie;

  // Plain flop chain, nothing between stages.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clock or negedge erst_n) begin
    if (!erst_n) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  logic [WIDTH-1:0] level;

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  // Count consecutive mismatch cycles; any match restarts the count,
  // and terminal count clears it, so it never wraps.
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    logic          filt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge erst_n) begin
      if (!erst_n) begin
        filt <= 1'b0;
        cnt  <= '0;
      end else if (sync[i] == filt) begin
        cnt  <= '0;
      end else if (cnt == TERM) begin
        filt <= sync[i];
        cnt  <= '0;
      end else begin
        cnt  <= cnt + CW'(1);
      end
    end

    assign level[i] = filt;
  end
`else
  assign level = sync;
`endif

  assign e300_gpio_i_ival = level;

  // Edge detect against last cycle's level.
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clock or negedge erst_n) begin
    if (!erst_n) begin
      prev <= '0;
    end else begin
      prev <= level;
    end
  end

  assign gpio_rise = level & ~prev;
  assign gpio_fall = ~level & prev;

endmodule
